// File: rtl/mesm6_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mesm6_bus_arbiter
//
// Shares the single CPU-side port of the memory mapper between two masters:
// master 0 (data access) and master 1 (instruction fetch / DMA). One request is
// latched at a time, run on the shared bus until the mapper answers with
// bus_done (or the timeout expires), and then reported back to its master with
// a one-cycle done pulse, the read data and an error flag.
//
// Parameters
//   RR_MODE  1 = round-robin between masters, 0 = fixed priority (m0 wins)
//   TIMEOUT  cycles allowed in BUSY before aborting with error; 0 = disabled
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   mN_addr/read/write/wdata  master N request, held until mN_done
//   mN_rdata/done/err         master N response, valid while mN_done = 1
//   bus_addr/read/write/wdata request towards the mapper (cpu_* side)
//   bus_rdata/done            response from the mapper
//   owner                     granted master, valid while busy = 1
//   busy                      transfer in progress (BUSY and RESP states)
// -----------------------------------------------------------------------------
module mesm6_bus_arbiter #(
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [14:0] m0_addr,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [47:0] m0_wdata,
    output logic [47:0] m0_rdata,
    output logic        m0_done,
    output logic        m0_err,

    input  logic [14:0] m1_addr,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [47:0] m1_wdata,
    output logic [47:0] m1_rdata,
    output logic        m1_done,
    output logic        m1_err,

    output logic [14:0] bus_addr,
    output logic        bus_read,
    output logic        bus_write,
    output logic [47:0] bus_wdata,
    input  logic [47:0] bus_rdata,
    input  logic        bus_done,

    output logic        owner,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Counter must hold TIMEOUT-1; keep at least one bit when timeout is off.
    localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic             last_grant;   // master granted most recently

    logic m0_req;
    logic m1_req;
    logic grant_m1;
    logic timeout_hit;

    assign m0_req      = m0_read | m0_write;
    assign m1_req      = m1_read | m1_write;
    assign timeout_hit = (TIMEOUT != 0) && (count == CNT_LAST);

    // Arbitration decision, only acted upon in IDLE.
    always_comb begin
        // NOTE: default first so every path assigns grant_m1 and no latch is inferred.
        grant_m1 = 1'b0;
        if (m0_req && m1_req) begin
            grant_m1 = (RR_MODE != 0) ? ~last_grant : 1'b0;
        end else begin
            grant_m1 = m1_req;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // Reset abandons any transfer in flight: the bus strobes drop on
            // this edge and no done is issued for it.
            state      <= S_IDLE;
            count      <= '0;
            last_grant <= 1'b1;
            bus_addr   <= '0;
            bus_read   <= 1'b0;
            bus_write  <= 1'b0;
            bus_wdata  <= '0;
            owner      <= 1'b0;
            busy       <= 1'b0;
            m0_rdata   <= '0;
            m0_done    <= 1'b0;
            m0_err     <= 1'b0;
            m1_rdata   <= '0;
            m1_done    <= 1'b0;
            m1_err     <= 1'b0;
        end else begin
            // NOTE: done/err default low each cycle, so a single set below
            // produces a pulse exactly one cycle wide.
            m0_done <= 1'b0;
            m0_err  <= 1'b0;
            m1_done <= 1'b0;
            m1_err  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (m0_req || m1_req) begin
                        state      <= S_BUSY;
                        count      <= '0;
                        owner      <= grant_m1;
                        last_grant <= grant_m1;
                        busy       <= 1'b1;
                        bus_addr   <= grant_m1 ? m1_addr  : m0_addr;
                        bus_wdata  <= grant_m1 ? m1_wdata : m0_wdata;
                        // read+write together is treated as a write
                        bus_write  <= grant_m1 ? m1_write : m0_write;
                        bus_read   <= grant_m1 ? (m1_read & ~m1_write)
                                               : (m0_read & ~m0_write);
                    end
                end

                S_BUSY: begin
                    count <= count + CNT_W'(1);
                    // bus_done takes precedence over a timeout in the same cycle
                    if (bus_done || timeout_hit) begin
                        state     <= S_RESP;
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        if (owner) begin
                            m1_done  <= 1'b1;
                            m1_err   <= ~bus_done;
                            m1_rdata <= bus_done ? bus_rdata : '0;
                        end else begin
                            m0_done  <= 1'b1;
                            m0_err   <= ~bus_done;
                            m0_rdata <= bus_done ? bus_rdata : '0;
                        end
                    end
                end

                S_RESP: begin
                    // The served master is still holding its request here;
                    // returning to IDLE first lets it drop the request.
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mesm6_bus_arbiter.sv
module tb_mesm6_bus_arbiter;

    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;

    // Main DUT: round-robin, TIMEOUT = 8
    logic [14:0] m0_addr = '0, m1_addr = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [47:0] m0_wdata = '0, m1_wdata = '0;
    logic [47:0] m0_rdata, m1_rdata;
    logic        m0_done, m0_err, m1_done, m1_err;
    logic [14:0] bus_addr;
    logic        bus_read, bus_write;
    logic [47:0] bus_wdata;
    logic [47:0] bus_rdata = '0;
    logic        bus_done = 1'b0;
    logic        owner, busy;

    // Second DUT: fixed priority, timeout disabled, zero-latency mapper
    logic [14:0] fp_m0_addr = 15'o0011, fp_m1_addr = 15'o0022;
    logic        fp_m0_read = 1'b0, fp_m0_write = 1'b0, fp_m1_read = 1'b0, fp_m1_write = 1'b0;
    logic [47:0] fp_m0_wdata = '0, fp_m1_wdata = '0;
    logic [47:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_m0_done, fp_m0_err, fp_m1_done, fp_m1_err;
    logic [14:0] fp_bus_addr;
    logic        fp_bus_read, fp_bus_write;
    logic [47:0] fp_bus_wdata;
    logic [47:0] fp_bus_rdata;
    logic        fp_bus_done;
    logic        fp_owner, fp_busy;

    assign fp_bus_done  = fp_bus_read | fp_bus_write;
    assign fp_bus_rdata = 48'h0000_0000_0001;

    mesm6_bus_arbiter #(.RR_MODE(1), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_addr(m0_addr), .m0_read(m0_read), .m0_write(m0_write), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_read(m1_read), .m1_write(m1_write), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .bus_addr(bus_addr), .bus_read(bus_read), .bus_write(bus_write), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_done(bus_done),
        .owner(owner), .busy(busy)
    );

    mesm6_bus_arbiter #(.RR_MODE(0), .TIMEOUT(0)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_addr(fp_m0_addr), .m0_read(fp_m0_read), .m0_write(fp_m0_write), .m0_wdata(fp_m0_wdata),
        .m0_rdata(fp_m0_rdata), .m0_done(fp_m0_done), .m0_err(fp_m0_err),
        .m1_addr(fp_m1_addr), .m1_read(fp_m1_read), .m1_write(fp_m1_write), .m1_wdata(fp_m1_wdata),
        .m1_rdata(fp_m1_rdata), .m1_done(fp_m1_done), .m1_err(fp_m1_err),
        .bus_addr(fp_bus_addr), .bus_read(fp_bus_read), .bus_write(fp_bus_write), .bus_wdata(fp_bus_wdata),
        .bus_rdata(fp_bus_rdata), .bus_done(fp_bus_done),
        .owner(fp_owner), .busy(fp_busy)
    );

    // Expected transfers, in the order the arbiter should serve them
    typedef struct {
        bit          master;
        bit          wr;
        logic [14:0] addr;
        logic [47:0] wdata;
        bit          err;
    } exp_t;

    // op: bit0 = read, bit1 = write
    typedef struct {
        logic [1:0]  op0;
        logic [1:0]  op1;
        logic [14:0] a0;
        logic [14:0] a1;
        logic [47:0] w0;
        logic [47:0] w1;
        int          lat;
        bit          exp_first;
        bit          exp_err;
    } vec_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   lat     = 0;     // mapper latency: bus_done this many cycles after strobe
    int   bus_cnt = 0;
    int   t_bus   = 0;
    int   done_cyc[2];

    function automatic logic [47:0] rdata_of(input logic [14:0] a);
        return {a, 1'b0, ~a, 1'b1, 16'hC0DE};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input bit m, input logic [1:0] op, input logic [14:0] a,
                            input logic [47:0] w, input bit err);
        exp_t e;
        e.master = m;
        e.wr     = op[1];
        e.addr   = a;
        e.wdata  = w;
        e.err    = err;
        exp_q.push_back(e);
    endtask

    // One clock: observe outputs, score completions, play master and mapper.
    task automatic step();
        exp_t e;
        bit   m;
        int   req_lat;
        @(posedge clk);
        #1;
        cyc++;

        if (m0_done || m1_done) begin
            m = m1_done;
            done_cyc[m] = cyc;
            check("done_exclusive", m0_done & m1_done, 1'b0);
            check("done_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("done_master", m, e.master);
                check("done_owner", owner, e.master);
                check("done_busy", busy, 1'b1);
                check("done_err", m ? m1_err : m0_err, e.err);
                if (!e.wr || e.err)
                    check("done_rdata", m ? m1_rdata : m0_rdata, e.err ? 48'h0 : rdata_of(e.addr));
                req_lat = ((lat < TO - 1) ? lat : TO - 1) + 1;
                check("done_latency", cyc - t_bus, req_lat);
            end
            // master drops its request on seeing done
            if (m) begin m1_read = 1'b0; m1_write = 1'b0; end
            else   begin m0_read = 1'b0; m0_write = 1'b0; end
        end

        if ((bus_read || bus_write) && bus_cnt == 0) begin
            t_bus = cyc;
            check("bus_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                check("bus_owner", owner, e.master);
                check("bus_busy", busy, 1'b1);
                check("bus_write", bus_write, e.wr);
                check("bus_read", bus_read, !e.wr);
                check("bus_addr", bus_addr, e.addr);
                if (e.wr) check("bus_wdata", bus_wdata, e.wdata);
            end
        end

        if (bus_read || bus_write) begin
            bus_done  = (bus_cnt == lat);
            bus_rdata = bus_done ? rdata_of(bus_addr) : 48'hBAD0_BAD0_BAD0;
            bus_cnt++;
        end else begin
            bus_done  = 1'b0;
            bus_rdata = 48'hBAD0_BAD0_BAD0;
            bus_cnt   = 0;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while ((m0_read || m0_write || m1_read || m1_write || busy) && n < budget);
        if (m0_read || m0_write || m1_read || m1_write || busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: transfers still pending=%0d after %0d cycles",
                     exp_q.size(), budget);
            m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
            exp_q.delete();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_bus_read"},  bus_read,  1'b0);
        check({tag, "_bus_write"}, bus_write, 1'b0);
        check({tag, "_bus_addr"},  bus_addr,  15'h0);
        check({tag, "_bus_wdata"}, bus_wdata, 48'h0);
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_owner"},     owner,     1'b0);
        check({tag, "_dones"},     {m0_done, m1_done}, 2'b00);
        check({tag, "_errs"},      {m0_err, m1_err},   2'b00);
        check({tag, "_m0_rdata"},  m0_rdata,  48'h0);
        check({tag, "_m1_rdata"},  m1_rdata,  48'h0);
    endtask

    initial begin
        vec_t vecs[9];
        vec_t v;
        bit   both;
        int   t_req;
        int   n_m0;
        bit   seen;

        // last grant starts at m1, so m0 wins the first tie
        vecs[0] = '{2'b01, 2'b01, 15'o0100, 15'o0200, 48'h0, 48'h0, 2, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 2'b01, 15'o0101, 15'o0201, 48'h0, 48'h0, 0, 1'b0, 1'b0};
        vecs[2] = '{2'b10, 2'b00, 15'o7777, 15'o0000, 48'hA5A5_0000_FFFF, 48'h0, 1, 1'b0, 1'b0};
        vecs[3] = '{2'b10, 2'b01, 15'o0300, 15'o0400, 48'h1111_2222_3333, 48'h0, 3, 1'b1, 1'b0};
        vecs[4] = '{2'b00, 2'b11, 15'o0000, 15'o0500, 48'h0, 48'hDEAD_BEEF_0042, 2, 1'b1, 1'b0};
        vecs[5] = '{2'b00, 2'b01, 15'o0000, 15'o0600, 48'h0, 48'h0, 7, 1'b1, 1'b0};
        vecs[6] = '{2'b00, 2'b01, 15'o0000, 15'o0700, 48'h0, 48'h0, 100, 1'b1, 1'b1};
        vecs[7] = '{2'b01, 2'b00, 15'o1000, 15'o0000, 48'h0, 48'h0, 8, 1'b0, 1'b1};
        vecs[8] = '{2'b01, 2'b01, 15'o1100, 15'o1200, 48'h0, 48'h0, 1, 1'b1, 1'b0};

        repeat (3) step();
        check_outputs_zero("reset");
        check("reset_fp_busy", fp_busy, 1'b0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < $size(vecs); i++) begin
            v   = vecs[i];
            lat = v.lat;
            {m0_write, m0_read} = v.op0;
            {m1_write, m1_read} = v.op1;
            m0_addr = v.a0; m0_wdata = v.w0;
            m1_addr = v.a1; m1_wdata = v.w1;
            both = (v.op0 != 2'b00) && (v.op1 != 2'b00);
            if (both) begin
                if (v.exp_first) begin
                    push_exp(1'b1, v.op1, v.a1, v.w1, v.exp_err);
                    push_exp(1'b0, v.op0, v.a0, v.w0, v.exp_err);
                end else begin
                    push_exp(1'b0, v.op0, v.a0, v.w0, v.exp_err);
                    push_exp(1'b1, v.op1, v.a1, v.w1, v.exp_err);
                end
            end else if (v.op0 != 2'b00) begin
                push_exp(1'b0, v.op0, v.a0, v.w0, v.exp_err);
            end else begin
                push_exp(1'b1, v.op1, v.a1, v.w1, v.exp_err);
            end
            drain(100);
            if (both)
                check("b2b_period", done_cyc[v.exp_first ? 0 : 1] - done_cyc[v.exp_first ? 1 : 0],
                      3 + v.lat);
            check("vec_all_served", exp_q.size(), 0);
        end

        // Single read: strobe one cycle after request, done four cycles after
        lat     = 2;
        t_req   = cyc;
        m0_addr = 15'o1234;
        m0_read = 1'b1;
        push_exp(1'b0, 2'b01, 15'o1234, 48'h0, 1'b0);
        drain(50);
        check("single_bus_latency", t_bus - t_req, 1);
        check("single_done_latency", done_cyc[0] - t_req, 4);

        // Reset mid-transfer: abort silently, then serve a fresh request
        lat      = 100;
        m1_addr  = 15'o4321;
        m1_wdata = 48'h0000_0000_1234;
        m1_write = 1'b1;
        push_exp(1'b1, 2'b10, 15'o4321, 48'h0000_0000_1234, 1'b0);
        step();
        step();
        check("abort_pre_busy", busy, 1'b1);
        reset_n = 1'b0;
        step();
        check_outputs_zero("abort");
        exp_q.delete();
        m1_write = 1'b0;
        reset_n  = 1'b1;
        step();
        check("abort_post_dones", {m0_done, m1_done}, 2'b00);
        check("abort_post_busy", busy, 1'b0);
        lat     = 1;
        m0_addr = 15'o0007;
        m0_read = 1'b1;
        push_exp(1'b0, 2'b01, 15'o0007, 48'h0, 1'b0);
        drain(50);
        check("abort_recovered", exp_q.size(), 0);

        // Fixed priority: m0 re-requesting continuously starves m1
        fp_m0_read = 1'b1;
        fp_m1_read = 1'b1;
        n_m0 = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (fp_m0_done) n_m0++;
            check("fp_m1_starved", fp_m1_done, 1'b0);
            if (fp_busy) check("fp_owner", fp_owner, 1'b0);
        end
        check("fp_m0_count", n_m0, 10);
        fp_m0_read = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (fp_m1_done) begin
                seen = 1'b1;
                check("fp_m1_rdata", fp_m1_rdata, 48'h0000_0000_0001);
                check("fp_m1_err", fp_m1_err, 1'b0);
                fp_m1_read = 1'b0;
            end
        end
        check("fp_m1_served", seen, 1'b1);
        fp_m1_read = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
